// File: rtl/mult_8x8_err_accum.sv
// Error-characterisation stage for an approximate 8x8 multiplier: compares the approximate product with
// the exact one and accumulates sum/max error distance and error count over a frame of N_SAMPLES samples.
module mult_8x8_err_accum #(
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [15:0]      R_approx,
  output logic             busy,
  output logic             out_valid,
  output logic [ACC_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [15:0]      err_cnt,
  output logic [15:0]      sample_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] N_LIM    = 16'(N_SAMPLES);
  localparam logic [15:0] LAST_IDX = 16'(N_SAMPLES - 1);

  state_t             state_q, state_d;
  logic [15:0]        acc_cnt_q, acc_cnt_d;
  logic               s1_vld_q, s1_vld_d;
  logic [15:0]        s1_exact_q, s1_exact_d;
  logic [15:0]        s1_approx_q, s1_approx_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [15:0]        max_q, max_d;
  logic [15:0]        err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               accept;
  logic               clear;
  logic [15:0]        ed;
  logic [ACC_W:0]     sum_ext;

  assign in_ready = (state_q == RUN) && (acc_cnt_q < N_LIM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    clear     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          acc_cnt_d = '0;
          clear     = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 16'd1;
          if (acc_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      // Only stage 1 can still hold a sample; stage 2 retires into the accumulators.
      DRAIN: begin
        if (!s1_vld_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_vld_d    = accept;
    s1_exact_d  = s1_exact_q;
    s1_approx_d = s1_approx_q;
    if (accept) begin
      s1_exact_d  = {8'd0, A} * {8'd0, B};
      s1_approx_d = R_approx;
    end
  end

  assign ed      = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                               : (s1_approx_q - s1_exact_q);
  assign sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - 16){1'b0}}, ed};

  always_comb begin
    sum_d = sum_q;
    max_d = max_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (clear) begin
      sum_d = '0;
      max_d = '0;
      err_d = '0;
      cnt_d = '0;
    end else if (s1_vld_q) begin
      sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      max_d = (ed > max_q) ? ed : max_q;
      err_d = err_q + {15'd0, |ed};
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_cnt_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_exact_q  <= s1_exact_d;
      s1_approx_q <= s1_approx_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign out_valid  = (state_q == DONE);
  assign sum_ed     = sum_q;
  assign max_ed     = max_q;
  assign err_cnt    = err_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_mult_8x8_err_accum.sv
// Bench for mult_8x8_err_accum: directed and random frames on a 32-bit and a 16-bit (saturating) instance.
module tb_mult_8x8_err_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        in_valid;
  logic [7:0]  A, B;
  logic [15:0] R;

  logic        rdy_a, busy_a, ov_a;
  logic [31:0] sum_a;
  logic [15:0] max_a, err_a, cnt_a;
  logic        rdy_b, busy_b, ov_b;
  logic [15:0] sum_b;
  logic [15:0] max_b, err_b, cnt_b;

  bit          sat_sel;
  logic        obs_rdy, obs_busy, obs_ov;
  logic [63:0] obs_sum;
  logic [15:0] obs_max, obs_err, obs_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int sA[4], sB[4], sR[4];

  always #5 clk = ~clk;

  mult_8x8_err_accum #(.N_SAMPLES(4), .ACC_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
    .A(A), .B(B), .R_approx(R), .busy(busy_a), .out_valid(ov_a),
    .sum_ed(sum_a), .max_ed(max_a), .err_cnt(err_a), .sample_cnt(cnt_a)
  );

  mult_8x8_err_accum #(.N_SAMPLES(4), .ACC_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
    .A(A), .B(B), .R_approx(R), .busy(busy_b), .out_valid(ov_b),
    .sum_ed(sum_b), .max_ed(max_b), .err_cnt(err_b), .sample_cnt(cnt_b)
  );

  assign obs_rdy  = sat_sel ? rdy_b  : rdy_a;
  assign obs_busy = sat_sel ? busy_b : busy_a;
  assign obs_ov   = sat_sel ? ov_b   : ov_a;
  assign obs_sum  = sat_sel ? {48'd0, sum_b} : {32'd0, sum_a};
  assign obs_max  = sat_sel ? max_b  : max_a;
  assign obs_err  = sat_sel ? err_b  : err_a;
  assign obs_cnt  = sat_sel ? cnt_b  : cnt_a;

  task automatic run_frame(input string name, input int mode);
    longint lim, esum;
    int     emax, eerr, ed, p, acc, cyc;
    bit     tog;
    logic [63:0] held_sum;
    lim  = sat_sel ? 64'd65535 : 64'hFFFF_FFFF;
    esum = 0; emax = 0; eerr = 0;
    for (int i = 0; i < 4; i++) begin
      p  = sA[i] * sB[i];
      ed = (p >= sR[i]) ? p - sR[i] : sR[i] - p;
      esum += ed;
      if (esum > lim) esum = lim;
      if (ed > emax) emax = ed;
      if (ed != 0) eerr++;
    end

    @(negedge clk);
    if (sat_sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    n_chk++;
    if (obs_ov !== 1'b0 || obs_busy !== 1'b1 || obs_cnt !== 16'd0 || obs_sum !== 64'd0) begin
      n_fail++;
      $display("FAIL %s start_clear: ov=%0b busy=%0b cnt=%0d sum=%0d, want 0 1 0 0",
               name, obs_ov, obs_busy, obs_cnt, obs_sum);
    end

    acc = 0; cyc = 0; tog = 1'b1;
    while (acc < 4 && cyc < 64) begin
      n_chk++;
      if (obs_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s in_ready_run: got %0b want 1 (accepted %0d)", name, obs_rdy, acc);
      end
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = tog;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      A = 8'(sA[acc]); B = 8'(sB[acc]); R = 16'(sR[acc]);
      @(negedge clk);
      if (in_valid) acc++;
      cyc++;
    end
    n_chk++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL %s accept_timeout: accepted %0d want 4", name, acc);
    end

    // Offer a fifth sample that must be refused and leave no trace.
    in_valid = (mode != 0);
    A = 8'd255; B = 8'd255; R = 16'd0;
    n_chk++;
    if (obs_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready_drop: got %0b want 0", name, obs_rdy);
    end
    n_chk++;
    if (obs_ov !== 1'b0 || obs_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s early_k0: ov=%0b busy=%0b want 0 1", name, obs_ov, obs_busy);
    end
    @(negedge clk);
    n_chk++;
    if (obs_ov !== 1'b0 || obs_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s early_k1: ov=%0b busy=%0b want 0 1", name, obs_ov, obs_busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (obs_ov !== 1'b1 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_k2: ov=%0b busy=%0b want 1 0", name, obs_ov, obs_busy);
    end
    n_chk++;
    if (obs_sum !== 64'(esum)) begin
      n_fail++;
      $display("FAIL %s sum_ed: got %0d want %0d", name, obs_sum, esum);
    end
    n_chk++;
    if (obs_max !== 16'(emax)) begin
      n_fail++;
      $display("FAIL %s max_ed: got %0d want %0d", name, obs_max, emax);
    end
    n_chk++;
    if (obs_err !== 16'(eerr)) begin
      n_fail++;
      $display("FAIL %s err_cnt: got %0d want %0d", name, obs_err, eerr);
    end
    n_chk++;
    if (obs_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL %s sample_cnt: got %0d want 4", name, obs_cnt);
    end
    held_sum = 64'(esum);
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs_ov !== 1'b1 || obs_sum !== held_sum || obs_cnt !== 16'd4 || obs_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s hold: ov=%0b sum=%0d cnt=%0d rdy=%0b want 1 %0d 4 0",
               name, obs_ov, obs_sum, obs_cnt, obs_rdy, held_sum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; in_valid = 1'b1;
    A = 8'd1; B = 8'd1; R = 16'd0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({rdy_a, busy_a, ov_a, sum_a, max_a, err_a, cnt_a} !== '0 ||
        {rdy_b, busy_b, ov_b, sum_b, max_b, err_b, cnt_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_zero: a rdy=%0b busy=%0b ov=%0b sum=%0d cnt=%0d, b rdy=%0b busy=%0b ov=%0b sum=%0d; want all 0",
               rdy_a, busy_a, ov_a, sum_a, cnt_a, rdy_b, busy_b, ov_b, sum_b);
    end
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b0 || rdy_b !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_beats_start: rdy_a=%0b busy_a=%0b rdy_b=%0b busy_b=%0b want 0",
               rdy_a, busy_a, rdy_b, busy_b);
    end
  endtask

  task automatic test_exact();
    sat_sel = 1'b0;
    sA = '{3, 255, 0, 16}; sB = '{5, 255, 7, 16}; sR = '{15, 65025, 0, 256};
    run_frame("exact", 0);
  endtask

  task automatic test_mixed();
    sat_sel = 1'b0;
    sA = '{15, 200, 2, 0}; sB = '{15, 100, 2, 0}; sR = '{224, 20100, 4, 5};
    run_frame("mixed", 0);
  endtask

  task automatic test_bubbles();
    sat_sel = 1'b0;
    sA = '{15, 200, 2, 0}; sB = '{15, 100, 2, 0}; sR = '{224, 20100, 4, 5};
    run_frame("bubbles", 1);
  endtask

  task automatic test_saturation();
    sat_sel = 1'b1;
    sA = '{255, 255, 255, 255}; sB = '{255, 255, 255, 255}; sR = '{0, 0, 0, 0};
    run_frame("saturation", 0);
    sat_sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sat_sel = 1'b0;
    sA = '{10, 20, 30, 40}; sB = '{10, 20, 30, 40}; sR = '{90, 400, 1000, 1700};
    run_frame("restart_1", 0);
    sA = '{1, 2, 3, 4}; sB = '{1, 2, 3, 4}; sR = '{1, 4, 9, 16};
    run_frame("restart_2", 0);
  endtask

  task automatic test_reset_mid();
    sat_sel = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    in_valid = 1'b1; A = 8'd255; B = 8'd255; R = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({rdy_a, busy_a, ov_a, sum_a, max_a, err_a, cnt_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%0b busy=%0b ov=%0b sum=%0d max=%0d err=%0d cnt=%0d want all 0",
               rdy_a, busy_a, ov_a, sum_a, max_a, err_a, cnt_a);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 16'd0 || sum_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: rdy=%0b busy=%0b cnt=%0d sum=%0d want 0 0 0 0",
               rdy_a, busy_a, cnt_a, sum_a);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    int p;
    for (int f = 0; f < 12; f++) begin
      sat_sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        sA[i] = int'($urandom_range(0, 255));
        sB[i] = int'($urandom_range(0, 255));
        p = sA[i] * sB[i];
        case ($urandom_range(0, 3))
          0:       sR[i] = p;
          1:       sR[i] = (p + int'($urandom_range(0, 300)) > 65535) ? 65535 : p + int'($urandom_range(0, 300));
          2:       sR[i] = (p > 300) ? p - int'($urandom_range(0, 300)) : 0;
          default: sR[i] = int'($urandom_range(0, 65535));
        endcase
      end
      run_frame("random", int'($urandom_range(0, 2)));
    end
    sat_sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sat_sel = 1'b0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; R = '0;
    test_reset();
    test_exact();
    test_mixed();
    test_bubbles();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
